// File: rtl/int16_to_fpa_conv.sv
// int16_to_fpa_conv
// Sequential converter from a signed 16-bit two's-complement integer to an
// IEEE754 half-precision value (1 sign / 5 exponent / 10 mantissa bits).
// It normalises the magnitude with one left shift per cycle and uses
// valid/ready handshakes on both the input and the output side.
//
// Ports:
//   clk_34          clock; all state updates happen on the rising edge
//   rst_34          synchronous, active-high reset
//   Int_In_34       signed operand
//   In_Valid_34     operand valid
//   In_Ready_34     converter can accept an operand (high only in IDLE)
//   FPOUT_34        FP16 result {sign, exp[4:0], mant[9:0]}
//   Out_Valid_34    result and flags are valid
//   Out_Ready_34    consumer accepts the result
//   Inexact_Flag_34 nonzero bits were discarded or rounded
//   Zero_Flag_34    operand was zero
//
// Build option:
//   FPA_CONV_RNE_EN  when defined, PACK rounds to nearest-even;
//                    otherwise the magnitude is truncated toward zero.
module int16_to_fpa_conv #(
  parameter int unsigned BIAS = 15
) (
  input  logic        clk_34,
  input  logic        rst_34,
  input  logic [15:0] Int_In_34,
  input  logic        In_Valid_34,
  output logic        In_Ready_34,
  output logic [15:0] FPOUT_34,
  output logic        Out_Valid_34,
  input  logic        Out_Ready_34,
  output logic        Inexact_Flag_34,
  output logic        Zero_Flag_34
);

  localparam int unsigned MAG_W = 16;
  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  // Exponent of a magnitude whose MSB already sits in bit 15.
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(15 + BIAS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               sign_q, sign_d;
  logic [15:0]        fpout_q, fpout_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               inexact_q, inexact_d;
  logic               zero_q, zero_d;

  logic [MAN_W-1:0]   mant_c;
  logic               guard_c;
  logic               sticky_c;
  logic [MAN_W-1:0]   mant_fin_c;
  logic [EXP_W-1:0]   exp_fin_c;
  logic [MAG_W-1:0]   abs_in_c;
`ifdef FPA_CONV_RNE_EN
  logic [MAN_W:0]     mant_inc_c;
`endif

  // Magnitude of the incoming operand; -32768 maps naturally to 16'h8000.
  always_comb begin
    abs_in_c = Int_In_34[15] ? MAG_W'(~Int_In_34 + 16'd1) : Int_In_34;
  end

  // Mantissa extraction and optional rounding from the normalised magnitude.
  always_comb begin
    mant_c     = mag_q[14:5];
    guard_c    = mag_q[4];
    sticky_c   = |mag_q[3:0];
    mant_fin_c = mant_c;
    exp_fin_c  = exp_q;
`ifdef FPA_CONV_RNE_EN
    mant_inc_c = {1'b0, mant_c} + (MAN_W+1)'(1);
    if (guard_c && (sticky_c || mant_c[0])) begin
      // Carry out of the mantissa bumps the exponent; max reachable is 30.
      mant_fin_c = mant_inc_c[MAN_W-1:0];
      if (mant_inc_c[MAN_W]) begin
        exp_fin_c = exp_q + EXP_W'(1);
      end
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    fpout_d     = fpout_q;
    out_valid_d = out_valid_q;
    inexact_d   = inexact_q;
    zero_d      = zero_q;

    unique case (state_q)
      IDLE: begin
        if (In_Valid_34 && in_ready_q) begin
          sign_d  = Int_In_34[15];
          mag_d   = abs_in_c;
          exp_d   = EXP_INIT;
          state_d = (Int_In_34 == 16'h0000) ? PACK : NORM;
        end
      end
      NORM: begin
        if (mag_q[MAG_W-1]) begin
          state_d = PACK;
        end else begin
          mag_d = {mag_q[MAG_W-2:0], 1'b0};
          exp_d = exp_q - EXP_W'(1);
        end
      end
      PACK: begin
        // A nonzero operand always leaves NORM with bit 15 set, so a zero
        // magnitude here identifies the zero operand.
        if (mag_q == '0) begin
          fpout_d   = 16'h0000;
          inexact_d = 1'b0;
          zero_d    = 1'b1;
        end else begin
          fpout_d   = {sign_q, exp_fin_c, mant_fin_c};
          inexact_d = guard_c | sticky_c;
          zero_d    = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (Out_Ready_34) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_34) begin
    if (rst_34) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      fpout_q     <= 16'h0000;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      inexact_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      fpout_q     <= fpout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      inexact_q   <= inexact_d;
      zero_q      <= zero_d;
    end
  end

  assign In_Ready_34     = in_ready_q;
  assign FPOUT_34        = fpout_q;
  assign Out_Valid_34    = out_valid_q;
  assign Inexact_Flag_34 = inexact_q;
  assign Zero_Flag_34    = zero_q;

endmodule

// File: doc/int16_to_fpa_conv.md
Name: int16_to_fpa_conv

Overview:
Sequential converter from signed 16-bit two's-complement integers to IEEE754 half-precision (1/5/10, bias 15). It is the producer side of the FP16 operand path and feeds Finput1_34/Finput2_34 of the FP16 adder. Normalization is iterative, one left shift per cycle, through an explicit state machine. Valid/ready handshakes are used on input and output.

Parameters:
BIAS, 15, exponent bias added to the unbiased exponent (the first exponent, 30, is computed as 15+BIAS).

Ports:
clk_34  input  1  clock; all state updates on the rising edge
rst_34  input  1  synchronous, active-high reset
Int_In_34  input  16  signed two's-complement operand
In_Valid_34  input  1  operand valid
In_Ready_34  output  1  converter can accept an operand
FPOUT_34  output  16  FP16 result {sign, exp[4:0], mant[9:0]}
Out_Valid_34  output  1  FPOUT_34 and flags valid
Out_Ready_34  input  1  consumer accepts the result
Inexact_Flag_34  output  1  nonzero bits were discarded (or rounded)
Zero_Flag_34  output  1  operand was 0

Behaviour:
- Clock and reset: one clock, clk_34. Reset rst_34 is synchronous and active-high.
- Reset values: state=IDLE, In_Ready_34=1, Out_Valid_34=0, FPOUT_34=16'h0000, both flags=0, internal mag/exp/sign=0.
- Reset mid-operation: any state returns to IDLE on the next edge. The in-flight operand is discarded and no output is produced.
- States: IDLE, NORM, PACK, HOLD.
- IDLE: In_Ready_34=1.
  - Accept occurs when In_Valid_34 && In_Ready_34 at an edge (edge E0).
  - Capture sign=Int_In_34[15], mag=|Int_In_34| as unsigned 16 bits (-32768 gives mag=16'h8000), exp=15+BIAS (=30).
  - Operand 0 goes to PACK. Any other operand goes to NORM.
- NORM: In_Ready_34=0.
  - If mag[15]==1, go to PACK.
  - Else mag<=mag<<1 and exp<=exp-1, stay in NORM.
  - Number of NORM cycles = lz+1, where lz = leading zeros of mag (0..15).
  - exp never underflows: minimum is 30-15=15.
- PACK, one cycle:
  - mant = mag[14:5], guard = mag[4], sticky = |mag[3:0].
  - Register FPOUT_34={sign,exp,mant}, Inexact_Flag_34=guard|sticky, Zero_Flag_34=(operand==0), Out_Valid_34<=1, then go to HOLD.
  - A zero operand gives FPOUT_34=16'h0000 (sign forced 0), Inexact=0.
- Latency: Out_Valid_34 rises at edge E(lz+2) for nonzero operands and at E1 for zero. Range: 2 (for -32768 and 32767 region) to 17 (for ±1).
- HOLD:
  - Outputs are stable while Out_Valid_34=1 and Out_Ready_34=0.
  - On an edge with Out_Ready_34=1: Out_Valid_34<=0, go to IDLE. In_Ready_34 is high in the following cycle.
  - No overlap: one operand in flight at a time. In_Valid_34 is ignored outside IDLE.
- Overflow is impossible: max |int| gives exp≤30. The exp=31 encoding is never produced.
- Width rules: mag is 16-bit unsigned and exp is 5-bit. All shifts discard MSB zeros only.

Optional Feature:
Macro: FPA_CONV_RNE_EN.
- Defined: round-to-nearest-even in PACK.
  - Round up when guard && (sticky || mant[0]).
  - If rounding carries out of mant (mant==10'h3FF), mant<=0 and exp<=exp+1. Max result is 16'h7800 (exp=30).
  - Inexact_Flag_34 is unchanged (guard|sticky).
  - Latency is unchanged.
- Undefined: truncation toward zero of the magnitude. mant = mag[14:5].

Test Plan:
- Reset then Int_In_34=16'h0001 -> FPOUT_34=16'h3C00, Out_Valid_34 at E17, Inexact=0, Zero=0.
- Int_In_34=16'hFFFE (-2) -> 16'hC000. Int_In_34=16'h0400 (1024) -> 16'h6400, Inexact=0.
- Int_In_34=16'h8000 (-32768) -> 16'hF800 at E2. Int_In_34=0 -> 16'h0000, Zero_Flag_34=1, Out_Valid_34 at E1.
- Int_In_34=16'h7FFF -> 16'h77FF without macro, 16'h7800 with FPA_CONV_RNE_EN; Inexact=1 in both. Int_In_34=16'h0801 -> 16'h6800 in both (tie to even), Inexact=1.
- Backpressure: hold Out_Ready_34=0 for 5 cycles after Out_Valid_34 -> FPOUT_34 and flags stable, In_Ready_34=0, and a new In_Valid_34 is ignored. Then Out_Ready_34=1 -> IDLE, next operand accepted.
- Assert rst_34 for 1 cycle while in NORM (operand 16'h0001) -> next cycle state IDLE, Out_Valid_34=0, FPOUT_34=0. A later operand 16'h0002 converts to 16'h4000 correctly.
